sdram_burst_ctrl: RTL and testbench

- Responder side of the SDRAM request/acknowledge handshake. Accepts sdram_wr_req / sdram_rd_req plus a 22-bit burst address from the FIFO address controller.
- Runs one full-page SDRAM burst per request: ACTIVE, WRITE/READ, BURST TERMINATE, PRECHARGE. Inserts periodic auto-refresh.
- Drives sdram_wr_ack (read strobe of the write FIFO) and sdram_rd_ack (write strobe of the read FIFO) for exactly one burst length.
- Sits between dcfifo_ctrl and the SDRAM pin/IO layer. Power-up init is done elsewhere and reported on sdram_init_done.

---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_ref_timer.sv | 35 +++
 rtl/sdram_burst_ctrl.sv | 152 +++++++++++++++
 tb/tb_sdram_burst_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst controller: command encodings,
// address field positions and the controller state enum.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int BANK_HI = 21;
  localparam int BANK_LO = 20;
  localparam int ROW_HI  = 19;
  localparam int ROW_LO  = 8;
  localparam int COL_HI  = 7;
  localparam int COL_LO  = 0;

  typedef enum logic [3:0] {
    S_IDLE, S_REF, S_REF_WAIT, S_ACT, S_RCD_WAIT, S_WR_DATA,
    S_RD_DATA, S_BST, S_WR_RECOV, S_PRE, S_RP_WAIT
  } state_t;

  // A full page is 256 columns; longer requests are cut to one page.
  function automatic logic [8:0] clamp_len(input logic [8:0] length);
    return (length > 9'd256) ? 9'd256 : length;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises pending once per REF_CYCLES clocks of
// initialised operation; the controller clears it when it starts a refresh.
module sdram_ref_timer #(
  parameter int REF_CYCLES = 781
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic pending
);

  localparam int CW = $clog2(REF_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (clr) pending <= 1'b0;
      // a new expiry on the clearing cycle must not be lost
      if (en) begin
        if (cnt == CW'(REF_CYCLES - 1)) begin
          cnt     <= '0;
          pending <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_burst_ctrl.sv
// Full-page SDRAM burst engine: ACTIVE, WRITE/READ, BURST TERMINATE, PRECHARGE
// per request, with periodic auto-refresh. Timing params must be >= 2 (TWR, CAS_LAT >= 1).
module sdram_burst_ctrl import sdram_pkg::*; #(
  parameter int TRCD       = 2,
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int TWR        = 2,
  parameter int CAS_LAT    = 3,
  parameter int REF_CYCLES = 781
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        sdram_wr_req,
  input  logic [21:0] sdram_wraddr,
  input  logic [8:0]  wr_length,
  output logic        sdram_wr_ack,
  input  logic [15:0] sdram_din,
  input  logic        sdram_rd_req,
  input  logic [21:0] sdram_rdaddr,
  input  logic [8:0]  rd_length,
  output logic        sdram_rd_ack,
  output logic [15:0] sdram_dout,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_a,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  input  logic [15:0] sdram_dq_in,
  output logic        busy
);

  state_t       state, state_nxt;
  logic [8:0]   cnt, len, rec_last;
  logic [21:0]  addr;
  logic         is_wr, ld_wr, ld_rd, ref_pending, ref_clr;
  logic [CAS_LAT:0] vld_pipe;

  sdram_ref_timer #(.REF_CYCLES(REF_CYCLES)) u_ref_timer (
    .clk     (clk_ref),
    .rst_n   (rst_n),
    .en      (sdram_init_done),
    .clr     (ref_clr),
    .pending (ref_pending)
  );

  // Writes wait out tWR; reads wait until the last word has left the pipe.
  assign rec_last = is_wr ? 9'(TWR - 1) : 9'(CAS_LAT - 1);

  always_comb begin
    state_nxt = state;
    ref_clr   = 1'b0;
    ld_wr     = 1'b0;
    ld_rd     = 1'b0;
    unique case (state)
      S_IDLE: if (sdram_init_done) begin
        if (ref_pending) begin
          state_nxt = S_REF;
          ref_clr   = 1'b1;
        end else if (sdram_wr_req && wr_length != 9'd0) begin
          state_nxt = S_ACT;
          ld_wr     = 1'b1;
        end else if (sdram_rd_req && rd_length != 9'd0) begin
          state_nxt = S_ACT;
          ld_rd     = 1'b1;
        end
      end
      S_REF:      state_nxt = S_REF_WAIT;
      S_REF_WAIT: if (cnt == 9'(TRFC - 2)) state_nxt = S_IDLE;
      S_ACT:      state_nxt = S_RCD_WAIT;
      S_RCD_WAIT: if (cnt == 9'(TRCD - 2)) state_nxt = is_wr ? S_WR_DATA : S_RD_DATA;
      S_WR_DATA,
      S_RD_DATA:  if (cnt == len - 9'd1) state_nxt = S_BST;
      S_BST:      state_nxt = S_WR_RECOV;
      S_WR_RECOV: if (cnt == rec_last) state_nxt = S_PRE;
      S_PRE:      state_nxt = S_RP_WAIT;
      S_RP_WAIT:  if (cnt == 9'(TRP - 2)) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len        <= '0;
      addr       <= '0;
      is_wr      <= 1'b0;
      vld_pipe   <= '0;
      sdram_dout <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 9'd0 : cnt + 9'd1;
      if (ld_wr) begin
        is_wr <= 1'b1;
        addr  <= sdram_wraddr;
        len   <= clamp_len(wr_length);
      end else if (ld_rd) begin
        is_wr <= 1'b0;
        addr  <= sdram_rdaddr;
        len   <= clamp_len(rd_length);
      end
      // bit k marks a READ-phase cycle k+1 clocks ago; DQ is valid CAS_LAT after
      vld_pipe <= {vld_pipe[CAS_LAT-1:0], state == S_RD_DATA};
      if (vld_pipe[CAS_LAT-1]) sdram_dout <= sdram_dq_in;
    end
  end

  assign sdram_rd_ack = vld_pipe[CAS_LAT];
  assign busy         = (state != S_IDLE);

  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_ba     = '0;
    sdram_a      = '0;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = '0;
    sdram_wr_ack = 1'b0;
    unique case (state)
      S_REF: sdram_cmd = CMD_REF;
      S_ACT: begin
        sdram_cmd = CMD_ACT;
        sdram_ba  = addr[BANK_HI:BANK_LO];
        sdram_a   = addr[ROW_HI:ROW_LO];
      end
      // FIFO data lags the strobe by one clock, so the strobe leads WRITE
      S_RCD_WAIT: sdram_wr_ack = is_wr && (cnt == 9'(TRCD - 2));
      S_WR_DATA: begin
        sdram_dq_oe  = 1'b1;
        sdram_dq_out = sdram_din;
        sdram_wr_ack = (cnt != len - 9'd1);
        if (cnt == 9'd0) begin
          sdram_cmd = CMD_WR;
          sdram_ba  = addr[BANK_HI:BANK_LO];
          sdram_a   = {4'b0000, addr[COL_HI:COL_LO]};
        end
      end
      S_RD_DATA: if (cnt == 9'd0) begin
        sdram_cmd = CMD_RD;
        sdram_ba  = addr[BANK_HI:BANK_LO];
        sdram_a   = {4'b0000, addr[COL_HI:COL_LO]};
      end
      S_BST: sdram_cmd = CMD_BST;
      S_PRE: begin
        sdram_cmd   = CMD_PRE;
        sdram_a[10] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_burst_ctrl.sv
// Directed bench for sdram_burst_ctrl: a per-cycle log of the DUT pins, a CL=3
// memory model, a table of burst vectors and hand sequences for corner cases.
module tb_sdram_burst_ctrl;
  import sdram_pkg::*;

  localparam int TRCD = 2, TRP = 2, TRFC = 7, TWR = 2, CL = 3;
  localparam int MAXC = 8192;

  logic        clk_ref = 1'b0, rst_n = 1'b0, init_done = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [21:0] wraddr = '0, rdaddr = '0;
  logic [8:0]  wr_length = '0, rd_length = '0;
  logic [15:0] din = '0, dq_in = '0;
  logic        wr_ack, rd_ack, dq_oe, busy;
  logic [15:0] dout, dq_out;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [11:0] a;

  always #5 clk_ref = ~clk_ref;

  sdram_burst_ctrl #(.TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TWR(TWR),
                     .CAS_LAT(CL), .REF_CYCLES(781)) u_dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .sdram_init_done(init_done),
    .sdram_wr_req(wr_req), .sdram_wraddr(wraddr), .wr_length(wr_length),
    .sdram_wr_ack(wr_ack), .sdram_din(din),
    .sdram_rd_req(rd_req), .sdram_rdaddr(rdaddr), .rd_length(rd_length),
    .sdram_rd_ack(rd_ack), .sdram_dout(dout),
    .sdram_cmd(cmd), .sdram_ba(ba), .sdram_a(a),
    .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe), .sdram_dq_in(dq_in),
    .busy(busy)
  );

  function automatic logic [15:0] exp_word(input logic [11:0] row, input logic [7:0] col);
    return {row[7:0] ^ 8'hC3, col};
  endfunction

  // ---- per-cycle log + write-data source + memory model ----
  int          cyc = 0;
  logic [3:0]  l_cmd [MAXC];
  logic [1:0]  l_ba  [MAXC];
  logic [11:0] l_a   [MAXC];
  logic        l_wack[MAXC], l_rack[MAXC], l_oe[MAXC], l_busy[MAXC];
  logic [15:0] l_dqo [MAXC], l_dout[MAXC], mdl[MAXC];
  logic        m_stream = 1'b0;
  logic [11:0] m_row = '0;
  logic [7:0]  m_col = '0;

  always @(negedge clk_ref) begin
    if (cyc < MAXC) begin
      l_cmd[cyc] = cmd;  l_ba[cyc] = ba;  l_a[cyc] = a;
      l_wack[cyc] = wr_ack; l_rack[cyc] = rd_ack; l_oe[cyc] = dq_oe;
      l_busy[cyc] = busy; l_dqo[cyc] = dq_out; l_dout[cyc] = dout;
    end
    if (wr_ack) din = 16'hA000 | 16'(cyc[11:0]);
    if (cmd == CMD_ACT) m_row = a;
    if (cmd == CMD_RD) begin m_stream = 1'b1; m_col = a[7:0]; end
    if (cmd == CMD_BST || cmd == CMD_WR || !rst_n) m_stream = 1'b0;
    if (m_stream && cyc + CL < MAXC) begin
      mdl[cyc + CL] = exp_word(m_row, m_col);
      m_col = m_col + 8'd1;
    end
    dq_in = (cyc < MAXC) ? mdl[cyc] : 16'h0;
    cyc = cyc + 1;
  end

  function automatic logic [3:0] cmd_at(input int t);
    return (t >= 0 && t < MAXC) ? l_cmd[t] : 4'hF;
  endfunction

  // ---- checking ----
  int n_pass = 0, n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk_ref); #1;
  endtask

  task automatic do_reset(input logic init);
    step();
    rst_n = 1'b0; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b1; init_done = init;
  endtask

  task automatic run_req(input bit wr, input logic [21:0] ad, input logic [8:0] ln,
                         output int t0, output int t1);
    bit seen = 0, done = 0;
    step();
    t0 = cyc;
    if (wr) begin wraddr = ad; wr_length = ln; wr_req = 1'b1; end
    else    begin rdaddr = ad; rd_length = ln; rd_req = 1'b1; end
    for (int i = 0; i < 600 && !done; i++) begin
      if (ln == 9'd0 && i == 20) break;
      step();
      if (wr_ack) wr_req = 1'b0;
      if (rd_ack) rd_req = 1'b0;
      if (busy) seen = 1; else if (seen) done = 1;
    end
    chk("burst_completes", done, ln != 9'd0);
    wr_req = 1'b0; rd_req = 1'b0;
    t1 = cyc;
  endtask

  task automatic check_burst(input bit wr, input logic [1:0] eba, input logic [11:0] erow,
                             input logic [7:0] ecol, input int L, input int t0, input int t1);
    int A = -1, nn = 0, fa = -1, la = -1, na = 0, pre = -1, blast = -1, bad = 0, nov = 0, k = 0, noe = 0;
    int efa, epre;
    for (int t = t0; t < t1 && t < MAXC; t++) begin
      if (l_cmd[t] != CMD_NOP) nn++;
      if (A < 0 && l_cmd[t] == CMD_ACT) A = t;
      if (l_cmd[t] == CMD_PRE) pre = t;
      if (wr ? l_wack[t] : l_rack[t]) begin na++; if (fa < 0) fa = t; la = t; end
      if (l_wack[t] && l_rack[t]) nov++;
      if (l_busy[t]) blast = t;
      if (wr && l_oe[t]) begin
        noe++;
        if (l_dqo[t] !== (16'hA000 | 16'((t - 1) & 12'hFFF))) bad++;
      end
      if (!wr && l_rack[t]) begin
        if (l_dout[t] !== exp_word(erow, 8'(int'(ecol) + k))) bad++;
        k++;
      end
    end
    chk("ack_count", na, L);
    chk("acks_overlap", nov, 0);
    if (L == 0) begin
      chk("len0_no_cmd", nn, 0);
      chk("len0_never_busy", blast, -1);
      return;
    end
    chk("cmd_count", nn, 4);
    chk("act_ba", l_ba[A], eba);
    chk("act_row", l_a[A], erow);
    chk("rw_cmd", cmd_at(A + TRCD), wr ? CMD_WR : CMD_RD);
    chk("rw_col", l_a[A + TRCD], {4'h0, ecol});
    chk("rw_ba", l_ba[A + TRCD], eba);
    chk("bst_cycle", cmd_at(A + TRCD + L), CMD_BST);
    efa  = wr ? A + TRCD - 1 : A + TRCD + CL + 1;
    epre = wr ? A + TRCD + L + TWR + 1 : A + TRCD + L + CL + 1;
    chk("first_ack", fa - A, efa - A);
    chk("last_ack", la - A, efa + L - 1 - A);
    chk("pre_cycle", pre - A, epre - A);
    if (pre >= 0) chk("pre_a10", l_a[pre][10], 1);
    chk("busy_fall", blast - A, epre + TRP - 1 - A);
    if (wr) chk("wr_oe_cycles", noe, L);
    chk("burst_data", bad, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [21:0] addr;
    logic [8:0]  len;
    logic [1:0]  ba;
    logic [11:0] row;
    logic [7:0]  col;
    int          acks;
  } vec_t;

  vec_t vt[7];

  initial begin
    int t0, t1, r, q, p, nref, nact, nw, nr, nov, fw, fr, nn;
    bit ok;

    vt[0] = '{1'b1, 22'h012345, 9'd8,   2'd0, 12'h123, 8'h45, 8};
    vt[1] = '{1'b1, 22'h3ABC12, 9'd5,   2'd3, 12'hABC, 8'h12, 5};
    vt[2] = '{1'b0, 22'h000100, 9'd256, 2'd0, 12'h001, 8'h00, 256};
    vt[3] = '{1'b0, 22'h2001F0, 9'd20,  2'd2, 12'h001, 8'hF0, 20};
    vt[4] = '{1'b1, 22'h100000, 9'd300, 2'd1, 12'h000, 8'h00, 256};
    vt[5] = '{1'b0, 22'h155555, 9'd1,   2'd1, 12'h555, 8'h55, 1};
    vt[6] = '{1'b1, 22'h000040, 9'd0,   2'd0, 12'h000, 8'h00, 0};

    // reset state
    do_reset(1'b1);
    chk("rst_cmd", cmd, CMD_NOP);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ba_a", {ba, a}, 0);
    chk("rst_dq_out", dq_out, 0);

    // table-driven bursts
    for (int i = 0; i < 7; i++) begin
      do_reset(1'b1);
      run_req(vt[i].wr, vt[i].addr, vt[i].len, t0, t1);
      check_burst(vt[i].wr, vt[i].ba, vt[i].row, vt[i].col, vt[i].acks, t0, t1);
    end

    // reset in the middle of a write burst
    do_reset(1'b1);
    step();
    wraddr = 22'h012345; wr_length = 9'd8; wr_req = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = dq_oe; end
    chk("midrst_reached_data", ok, 1);
    rst_n = 1'b0; wr_req = 1'b0;
    step();
    chk("midrst_cmd", cmd, CMD_NOP);
    chk("midrst_acks", {wr_ack, rd_ack}, 0);
    chk("midrst_dq_oe", dq_oe, 0);
    chk("midrst_busy", busy, 0);
    step(); step();
    rst_n = 1'b1;

    // no commands while init is low; init falling mid-burst finishes the burst only
    do_reset(1'b0);
    step();
    t0 = cyc;
    wraddr = 22'h000200; wr_length = 9'd4; wr_req = 1'b1;
    rdaddr = 22'h000300; rd_length = 9'd4;
    repeat (20) step();
    nn = 0;
    for (int t = t0; t < cyc; t++) if (l_cmd[t] != CMD_NOP || l_busy[t]) nn++;
    chk("noinit_idle", nn, 0);
    init_done = 1'b1;
    t0 = cyc;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = wr_ack; end
    init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b1;
    repeat (40) step();
    rd_req = 1'b0;
    nact = 0; nw = 0; p = 0;
    for (int t = t0; t < cyc; t++) begin
      if (l_cmd[t] == CMD_ACT) nact++;
      if (l_cmd[t] == CMD_PRE) p++;
      if (l_wack[t]) nw++;
    end
    chk("initfall_one_act", nact, 1);
    chk("initfall_wr_acks", nw, 4);
    chk("initfall_precharged", p, 1);

    // simultaneous requests: write first, then read, acks disjoint
    do_reset(1'b1);
    step();
    t0 = cyc;
    wraddr = 22'h000A00; wr_length = 9'd4; wr_req = 1'b1;
    rdaddr = 22'h000B00; rd_length = 9'd4; rd_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (wr_ack) wr_req = 1'b0;
      if (rd_ack) rd_req = 1'b0;
      if (!wr_req && !rd_req && !busy) break;
    end
    chk("both_served", {wr_req, rd_req, busy}, 0);
    wr_req = 1'b0; rd_req = 1'b0;
    nw = 0; nr = 0; nov = 0; fw = -1; fr = -1;
    for (int t = t0; t < cyc; t++) begin
      nw += int'(l_wack[t]); nr += int'(l_rack[t]);
      if (l_wack[t] && l_rack[t]) nov++;
      if (fw < 0 && l_cmd[t] == CMD_WR) fw = t;
      if (fr < 0 && l_cmd[t] == CMD_RD) fr = t;
    end
    chk("both_wr_acks", nw, 4);
    chk("both_rd_acks", nr, 4);
    chk("both_no_overlap", nov, 0);
    chk("both_write_first", (fw >= 0) && (fr > fw), 1);

    // refresh expiring during a long read, with a write waiting behind it
    do_reset(1'b1);
    repeat (600) step();
    t0 = cyc;
    rdaddr = 22'h000100; rd_length = 9'd256; rd_req = 1'b1;
    ok = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (rd_ack && rd_req) begin
        rd_req = 1'b0;
        wraddr = 22'h000C00; wr_length = 9'd4; wr_req = 1'b1;
      end
      if (wr_ack) begin wr_req = 1'b0; ok = 1; end
      if (ok && !busy) break;
    end
    chk("ref_write_served", ok && !busy, 1);
    wr_req = 1'b0; rd_req = 1'b0;
    p = -1; r = -1; q = -1; nref = 0; nr = 0;
    for (int t = t0; t < cyc; t++) begin
      if (l_cmd[t] == CMD_REF) nref++;
      nr += int'(l_rack[t]);
      if (p < 0 && l_cmd[t] == CMD_PRE) p = t;
      else if (p >= 0 && r < 0 && l_cmd[t] != CMD_NOP) r = t;
      else if (r >= 0 && q < 0 && l_cmd[t] != CMD_NOP) q = t;
    end
    chk("ref_read_acks", nr, 256);
    chk("ref_count", nref, 1);
    chk("ref_after_pre_cmd", cmd_at(r), CMD_REF);
    chk("ref_after_pre_gap", r - p, TRP + 1);
    chk("ref_next_cmd", cmd_at(q), CMD_ACT);
    chk("ref_trfc_gap", q - r, TRFC + 1);
    chk("ref_then_write", cmd_at(q + TRCD), CMD_WR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
